// File: rtl/fir_nibble_seq_if.sv
// Sample, result and coefficient-config signals of the FIR nibble sequencer.
// Handshake: a sample moves when x_valid && x_ready are both high at a rising
// clk edge; y_valid is a one-cycle pulse with no backpressure; a cfg write is
// a single-cycle cfg_we strobe that the sequencer may silently drop.
interface fir_nibble_seq_if #(
    parameter int AW = 3
) ();
    logic [7:0]    x_data;
    logic          x_valid;
    logic          x_ready;
    logic [15:0]   y_data;
    logic          y_valid;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [7:0]    cfg_data;
    logic          cfg_busy;

    modport master (
        output x_data, x_valid, cfg_we, cfg_addr, cfg_data,
        input  x_ready, y_data, y_valid, cfg_busy
    );

    modport slave (
        input  x_data, x_valid, cfg_we, cfg_addr, cfg_data,
        output x_ready, y_data, y_valid, cfg_busy
    );
endinterface

// File: rtl/fir_nibble_seq.sv
// Sequencer for a nibble-serial FIR PE chain: serializes 8-bit samples into
// 4-cycle frames, tracks frames through the chain with a tag pipe, reassembles
// 16-bit results and holds the per-tap coefficients.
module fir_nibble_seq #(
    parameter int TAPS = 8,
    parameter int LAT  = 40,
    parameter int AW   = 3
) (
    input  logic                clk,
    input  logic                reset,
    fir_nibble_seq_if.slave     bus,
    output logic [TAPS*8-1:0]   coef,
    output logic [3:0]          pe_xin,
    output logic [3:0]          pe_yin,
    output logic                pe_rdy,
    input  logic [3:0]          pe_yout,
    input  logic                pe_vld,
    output logic                sync_err,
    output logic [1:0]          fsm_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [1:0]      ph, ph_n;
    logic [7:0]      xbuf;
    logic            fvld;
    logic            accept;
    logic [LAT-1:0]  tag;
    logic            tag_out;
    logic            tag_empty;
    logic            cap_busy;
    logic [1:0]      cap_cnt;
    logic [11:0]     cap_buf;
    logic [15:0]     y_data_q;
    logic            y_valid_q;
    logic [AW-1:0]   addr;
    logic            cfg_ok;

    assign bus.x_ready  = (state == IDLE) || (ph == 2'd3);
    assign accept       = bus.x_valid && bus.x_ready;
    assign bus.cfg_busy = (state != IDLE);
    assign bus.y_data   = y_data_q;
    assign bus.y_valid  = y_valid_q;
    assign pe_yin       = 4'd0;
    assign fsm_state    = state;
    assign tag_out      = tag[LAT-1];
    assign tag_empty    = ~|tag;
    assign addr         = bus.cfg_addr;
    assign cfg_ok       = bus.cfg_we && (state == IDLE) && (32'(addr) < TAPS);

    // Frame drive: high nibble on ph0, low nibble on ph1, zeros otherwise and for bubbles.
    always_comb begin
        pe_xin = 4'd0;
        pe_rdy = 1'b0;
        if (state != IDLE && fvld) begin
            case (ph)
                2'd0: begin
                    pe_xin = xbuf[7:4];
                    pe_rdy = 1'b1;
                end
                2'd1:    pe_xin = xbuf[3:0];
                default: pe_xin = 4'd0;
            endcase
        end
    end

    // Next state and frame phase; frames only change at the ph3 boundary.
    always_comb begin
        state_n = state;
        ph_n    = (state == IDLE) ? 2'd0 : ph + 2'd1;
        case (state)
            IDLE: begin
                if (accept) state_n = RUN;
            end
            RUN: begin
                if (ph == 2'd3 && !accept) state_n = DRAIN;
            end
            DRAIN: begin
                if (ph == 2'd3) begin
                    if (accept) state_n = RUN;
                    else if (tag_empty && !cap_busy) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, phase and the sample buffer; a ph3 boundary without a sample makes a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ph    <= 2'd0;
            xbuf  <= 8'd0;
            fvld  <= 1'b0;
        end else begin
            state <= state_n;
            ph    <= ph_n;
            if (accept) begin
                xbuf <= bus.x_data;
                fvld <= 1'b1;
            end else if (state != IDLE && ph == 2'd3) begin
                fvld <= 1'b0;
            end
        end
    end

    // Tag pipe mirrors the chain latency so a result is expected exactly LAT cycles after ph0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tag <= '0;
        else       tag <= {tag[LAT-2:0], pe_rdy};
    end

    // Result capture: four nibbles LSB first, y_data updates only when the full word is ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_busy  <= 1'b0;
            cap_cnt   <= 2'd0;
            cap_buf   <= 12'd0;
            y_data_q  <= 16'd0;
            y_valid_q <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            if (tag_out) begin
                cap_buf[3:0] <= pe_yout;
                cap_cnt      <= 2'd1;
                cap_busy     <= 1'b1;
                if (!pe_vld) sync_err <= 1'b1;
            end else if (cap_busy) begin
                cap_cnt <= cap_cnt + 2'd1;
                case (cap_cnt)
                    2'd1: cap_buf[7:4]  <= pe_yout;
                    2'd2: cap_buf[11:8] <= pe_yout;
                    default: begin
                        y_data_q  <= {pe_yout, cap_buf};
                        y_valid_q <= 1'b1;
                        cap_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Coefficient registers: writable only while idle and only for existing taps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coef <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (cfg_ok && 32'(addr) == k) coef[8*k +: 8] <= bus.cfg_data;
            end
        end
    end
endmodule

// File: tb/tb_fir_nibble_seq.sv
// Bench for fir_nibble_seq: an emulated PE chain answers the DUT's frames, and
// a scoreboard checks every result against an FIR model of the accepted samples.
module tb_fir_nibble_seq;
    localparam int TAPS = 8;
    localparam int LAT  = 40;
    localparam int AW   = 4;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fir_nibble_seq_if #(.AW(AW)) bus ();
    logic [TAPS*8-1:0] coef;
    logic [3:0]        pe_xin, pe_yin, pe_yout;
    logic              pe_rdy, pe_vld, sync_err;
    logic [1:0]        fsm_state;

    fir_nibble_seq #(.TAPS(TAPS), .LAT(LAT), .AW(AW)) dut (
        .clk(clk), .reset(reset), .bus(bus), .coef(coef),
        .pe_xin(pe_xin), .pe_yin(pe_yin), .pe_rdy(pe_rdy),
        .pe_yout(pe_yout), .pe_vld(pe_vld), .sync_err(sync_err),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    int          exp_t[$];
    logic [7:0]  cm[TAPS];
    logic [7:0]  mhist[TAPS];
    int          last_acc;
    bit          vld_kill = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] fir_calc(input logic [7:0] h[TAPS], input logic [7:0] c[TAPS]);
        int acc = 0;
        for (int k = 0; k < TAPS; k++) acc += int'($signed(h[k])) * int'($signed(c[k]));
        return acc[15:0];
    endfunction

    function automatic logic [TAPS*8-1:0] cm_packed();
        logic [TAPS*8-1:0] v = '0;
        for (int k = 0; k < TAPS; k++) v[8*k +: 8] = cm[k];
        return v;
    endfunction

    // ---------------- emulated PE chain ----------------
    logic [7:0] ehist[TAPS];
    logic [3:0] sched_n[int];
    bit         pend = 1'b0;
    logic [3:0] pend_hi;
    int         pend_t;

    always @(negedge clk) begin
        logic [7:0] ec[TAPS];
        logic [15:0] ey;
        if (reset) begin
            pend = 1'b0;
            sched_n.delete();
            for (int k = 0; k < TAPS; k++) ehist[k] = 8'd0;
            pe_yout = 4'd0;
            pe_vld  = 1'b0;
        end else begin
            pe_yout = sched_n.exists(cyc) ? sched_n[cyc] : 4'd0;
            pe_vld  = sched_n.exists(cyc) && !vld_kill;
            if (pend) begin
                for (int k = TAPS - 1; k > 0; k--) ehist[k] = ehist[k-1];
                ehist[0] = {pend_hi, pe_xin};
                for (int k = 0; k < TAPS; k++) ec[k] = coef[8*k +: 8];
                ey = fir_calc(ehist, ec);
                for (int i = 0; i < 4; i++) sched_n[pend_t + LAT + i] = ey[4*i +: 4];
                pend = 1'b0;
            end
            if (pe_rdy) begin
                pend    = 1'b1;
                pend_hi = pe_xin;
                pend_t  = cyc;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset && bus.y_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_y_valid: got y_data %0h at cycle %0d want none", bus.y_data, cyc);
            end else begin
                chk("y_data", bus.y_data, exp_q.pop_front());
                chk("y_latency", cyc, exp_t.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.delete();
        exp_t.delete();
        for (int k = 0; k < TAPS; k++) begin
            cm[k] = 8'd0;
            mhist[k] = 8'd0;
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Present one sample; returns at the ph0 cycle of its frame.
    task automatic send(input logic [7:0] x);
        int n = 0;
        bus.x_data  = x;
        bus.x_valid = 1'b1;
        while (!bus.x_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.x_ready) begin
            chk("x_ready_timeout", 0, 1);
        end else begin
            last_acc = cyc;
            for (int k = TAPS - 1; k > 0; k--) mhist[k] = mhist[k-1];
            mhist[0] = x;
            exp_q.push_back(fir_calc(mhist, cm));
            exp_t.push_back(cyc + LAT + 5);
            @(negedge clk);
        end
        bus.x_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [7:0] d, input bit busy_exp);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        chk("cfg_busy", bus.cfg_busy, busy_exp);
        if (!busy_exp && a < TAPS) cm[a] = d;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        chk("coef", coef, cm_packed());
    endtask

    task automatic wait_idle();
        int n = 0;
        while (fsm_state != S_IDLE && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", fsm_state, S_IDLE);
        repeat (6) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] xin_exp[4];
        int accs[$];
        logic [3:0] xin_or;
        int yv_cnt;

        bus.x_data = 8'd0;
        bus.x_valid = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = 8'd0;
        @(negedge clk);
        do_reset();

        // reset state
        chk("rst_x_ready", bus.x_ready, 1);
        chk("rst_state", fsm_state, S_IDLE);
        chk("rst_y_valid", bus.y_valid, 0);
        chk("rst_y_data", bus.y_data, 0);
        chk("rst_coef", coef, 0);
        chk("rst_pe_rdy", pe_rdy, 0);
        chk("rst_sync_err", sync_err, 0);

        // single sample with coef k+1
        for (int k = 0; k < TAPS; k++) cfg_write(AW'(k), 8'(k + 1), 1'b0);
        send(8'h01);
        xin_exp[0] = 4'd0; xin_exp[1] = 4'd1; xin_exp[2] = 4'd0; xin_exp[3] = 4'd0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_pe_xin", pe_xin, xin_exp[i]);
            chk("t1_pe_rdy", pe_rdy, i == 0);
            chk("t1_pe_yin", pe_yin, 0);
            @(negedge clk);
        end
        wait_idle();

        // continuous stream
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom_range(0, 255)));
            accs.push_back(last_acc);
            chk("t2_state_run", fsm_state, S_RUN);
        end
        for (int i = 1; i < 16; i++) chk("t2_accept_spacing", accs[i] - accs[i-1], 4);
        wait_idle();

        // gap of two bubble frames, then resume
        for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)));
        repeat (3) @(negedge clk);
        xin_or = 4'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t3_bubble_rdy", pe_rdy, 0);
            xin_or |= pe_xin;
            if (i == 1) chk("t3_state_drain", fsm_state, S_DRAIN);
        end
        chk("t3_bubble_xin", xin_or, 0);
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom_range(0, 255)));
            chk("t3_state_resume", fsm_state, S_RUN);
        end
        wait_idle();

        // config writes while busy are dropped, idle writes land, out-of-range ignored
        send(8'($urandom_range(0, 255)));
        cfg_write(AW'(2), 8'hAA, 1'b1);
        repeat (6) @(negedge clk);
        chk("t4_state_drain", fsm_state, S_DRAIN);
        cfg_write(AW'(3), 8'h55, 1'b1);
        wait_idle();
        for (int k = 0; k < TAPS; k++) cfg_write(AW'(k), 8'($urandom_range(0, 255)), 1'b0);
        cfg_write(AW'(TAPS), 8'h77, 1'b0);
        cfg_write(AW'(15), 8'h33, 1'b0);
        for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 255)));
        wait_idle();

        // reset mid-flight
        send(8'($urandom_range(0, 255)));
        wait_until(last_acc + 20);
        do_reset();
        chk("t5_x_ready", bus.x_ready, 1);
        chk("t5_state", fsm_state, S_IDLE);
        chk("t5_coef", coef, 0);
        chk("t5_y_data", bus.y_data, 0);
        chk("t5_pe_xin", pe_xin, 0);
        chk("t5_cfg_busy", bus.cfg_busy, 0);
        yv_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.y_valid) yv_cnt++;
        end
        chk("t5_no_y_valid", yv_cnt, 0);

        // missing pe_vld makes sync_err sticky
        for (int k = 0; k < TAPS; k++) cfg_write(AW'(k), 8'($urandom_range(0, 255)), 1'b0);
        vld_kill = 1'b1;
        send(8'($urandom_range(0, 255)));
        wait_until(last_acc + LAT);
        chk("t6_sync_err_before", sync_err, 0);
        wait_until(last_acc + LAT + 2);
        chk("t6_sync_err_set", sync_err, 1);
        vld_kill = 1'b0;
        wait_idle();
        send(8'($urandom_range(0, 255)));
        wait_idle();
        chk("t6_sync_err_sticky", sync_err, 1);
        do_reset();
        chk("t6_sync_err_cleared", sync_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
